// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // The bit counter is at least one bit wide so WIDTH=2 still has a legal range.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = x - y - bin, bout set on underflow.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock with a start/busy/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             bw;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bw),
        .d    (d),
        .bout (bo)
    );

    // Result bits enter from the MSB side; on the last bit this is the full difference.
    assign res_next = {d, res_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bw         <= 1'b0;
            cnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        bw    <= borrow_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[WIDTH-1:1];
                    bw     <= bo;
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= bo;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: cycle model plus literal checks, exhaustive cell and WIDTH=4 sweeps.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    logic         start4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic         bin4;
    logic         busy4;
    logic         done4;
    logic [3:0]   diff4;
    logic         bo4;

    logic fx, fy, fb, fd, fbo;

    int vec_count  = 0;
    int miscompares = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .borrow_in  (bin4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bo4)
    );

    full_subtractor u_fs (
        .x    (fx),
        .y    (fy),
        .bin  (fb),
        .d    (fd),
        .bout (fbo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level reference: outputs follow from operand arithmetic and a bit countdown.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bo   = 1'b0;
    logic [W:0]   m_pend = '0;
    int           m_left = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_diff = '0;
            m_bo   = 1'b0;
            m_left = 0;
        end
        checkOutput("cycle", 32'({busy, done, borrow_out, diff}), 32'({m_busy, m_done, m_bo, m_diff}));
        if (!rst) begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_diff = m_pend[W-1:0];
                    m_bo   = m_pend[W];
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = W;
                m_pend = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic bin_v);
        a         = a_v;
        b         = b_v;
        borrow_in = bin_v;
        start     = 1'b1;
    endtask

    // Counts edges until done; can inject a zero-operand start pulse at edge pulse_at.
    task automatic waitDone(input int n0, input int pulse_at, input bit hold, output int n);
        bit got;
        got = 1'b0;
        n   = n0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                got = 1'b1;
            end else begin
                #1;
                if (n == pulse_at) begin
                    start = 1'b1;
                    a     = '0;
                    b     = '0;
                end else if (!hold) begin
                    start = 1'b0;
                end
            end
        end
        checkOutput("done_seen", 32'(got), 32'd1);
    endtask

    task automatic runOp(input string name, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         input logic bin_v, input logic [W-1:0] exp_d, input logic exp_bo);
        int n;
        applyStimulus(a_v, b_v, bin_v);
        waitDone(0, -1, 1'b0, n);
        checkOutput({name, "_result"}, 32'({borrow_out, diff}), 32'({exp_bo, exp_d}));
        checkOutput({name, "_latency"}, 32'(n), 32'(W + 1));
    endtask

    initial begin
        int  n;
        int  r;
        bit  abort;
        logic [4:0] ex4;

        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        start4    = 1'b0;
        a4        = '0;
        b4        = '0;
        bin4      = 1'b0;
        fx        = 1'b0;
        fy        = 1'b0;
        fb        = 1'b0;
        abort     = 1'b0;

        #1;
        checkOutput("reset_state", 32'({busy, done, borrow_out, diff}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            {fx, fy, fb} = 3'(i);
            #1;
            r = int'(fx) - int'(fy) - int'(fb);
            checkOutput("full_sub", 32'({fbo, fd}), 32'({r < 0, r[0]}));
        end

        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;

        runOp("basic", 8'd5, 8'd3, 1'b0, 8'h02, 1'b0);
        runOp("wrap", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        runOp("bin_chain", 8'h80, 8'h80, 1'b1, 8'hFF, 1'b1);

        // start pulsed while running must not disturb the result or timing
        applyStimulus(8'd100, 8'd1, 1'b0);
        waitDone(0, 3, 1'b0, n);
        checkOutput("ignore_result", 32'({borrow_out, diff}), 32'({1'b0, 8'd99}));
        checkOutput("ignore_latency", 32'(n), 32'(W + 1));
        #1 start = 1'b0;
        @(posedge clk);
        #2;

        applyStimulus(8'd10, 8'd20, 1'b0);
        waitDone(0, -1, 1'b1, n);
        checkOutput("b2b_first", 32'({borrow_out, diff}), 32'({1'b1, 8'hF6}));
        #1;
        a = 8'd20;
        b = 8'd10;
        @(posedge clk);
        #1;
        checkOutput("b2b_hold", 32'({busy, done, diff}), 32'({1'b1, 1'b0, 8'hF6}));
        #1 start = 1'b0;
        waitDone(1, -1, 1'b0, n);
        checkOutput("b2b_second", 32'({borrow_out, diff}), 32'({1'b0, 8'd10}));
        checkOutput("b2b_latency", 32'(n), 32'(W + 1));
        @(posedge clk);
        #2;

        applyStimulus(8'd200, 8'd55, 1'b0);
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async", 32'({busy, done, borrow_out, diff}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("no_done", 32'(done), 32'd0);
        end
        #1;
        runOp("after_rst", 8'd200, 8'd55, 1'b0, 8'h91, 1'b0);

        // WIDTH=4 instance against a - b - borrow_in over every operand combination
        for (int k = 0; k < 512 && !abort; k++) begin
            bit got;
            a4     = 4'(k >> 5);
            b4     = 4'(k >> 1);
            bin4   = k[0];
            start4 = 1'b1;
            ex4    = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
            got    = 1'b0;
            n      = 0;
            while (!got && n < 20) begin
                @(posedge clk);
                n++;
                #1;
                if (done4) got = 1'b1;
                else start4 = 1'b0;
            end
            start4 = 1'b0;
            vec_count++;
            if (!got || {busy4, bo4, diff4} !== {1'b0, ex4} || n != 5) begin
                miscompares++;
                abort = 1'b1;
                $display("[TB] FAIL w4_sweep a=%0d b=%0d bin=%0d: got bo=%0b diff=%0d edges=%0d, expected bo=%0b diff=%0d edges=5",
                         a4, b4, bin4, bo4, diff4, n, ex4[4], ex4[3:0]);
            end
            #1;
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a − b − borrow_in, one bit per clock, LSB first.
- Built around a registered full-subtractor cell, so it is the inverse-direction counterpart of the combinational full adder.
- Start/busy/done handshake lets a controller or testbench issue back-to-back operations.
- Used in the arithmetic workshop blocks wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only when state is IDLE or DONE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- borrow_in  input  1  initial borrow; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  difference; held stable from done until the next accepted start.
- borrow_out  output  1  final borrow; 1 iff a < b + borrow_in (unsigned).

Behaviour:
- Reset: asynchronous and active-high. Forces these values immediately, independent of clk:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, borrow_out = 0
  - shift registers = 0, bit counter = 0, borrow flop = 0
- Reset asserted mid-operation aborts the operation. No done pulse is produced.
- States: IDLE, RUN, DONE.
- Accepted start at edge k (state IDLE or DONE):
  - load shift registers with a and b
  - load borrow flop with borrow_in
  - clear counter
  - state becomes RUN, busy = 1
  - diff and borrow_out keep their previous values until the new result completes
- Each RUN edge:
  - full_subtractor cell computes d = x^y^bw and bo = (~x&y) | (~(x^y)&bw), where x and y are the shift-register LSBs and bw is the borrow flop
  - d shifts into the result register from the MSB side
  - borrow flop takes bo
  - counter increments
- Termination: on the RUN edge where counter == WIDTH−1:
  - state becomes DONE, busy = 0, done = 1
  - diff = assembled result register; borrow_out = bo
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 edges after the start sample.
- DONE lasts one cycle. The next edge goes to IDLE, unless start = 1, which is accepted as a new start (back-to-back).
- start while RUN is ignored. Operand changes while RUN have no effect.
- Arithmetic is modulo 2^WIDTH: diff = (a − b − borrow_in) mod 2^WIDTH.
  - Wrap-around example: 0 − 1 gives diff = all ones, borrow_out = 1.
- Counter width is $clog2(WIDTH). It must not overflow for non-power-of-two WIDTH.

Decomposition:
- Package serial_arith_pkg holds the state enum (IDLE, RUN, DONE) and the counter-width function/constant.
- One natural sub-module: full_subtractor, a combinational 1-bit cell with inputs x, y, bin and outputs d, bout. It is instantiated once and also testable exhaustively on its own.
- Target RTL size is about 150–200 lines total.

Test Plan:
- Reset mid-RUN: start with a=200, b=55, then assert rst after 3 edges → outputs go to 0 immediately. No done follows, and the next start works normally.
- Basic: WIDTH=8, a=5, b=3, borrow_in=0, start for 1 cycle → busy=1 for 8 cycles, then done pulses once with diff=2, borrow_out=0.
- Borrow chain: a=0x00, b=0x01, borrow_in=0 → diff=0xFF, borrow_out=1. Also a=0x80, b=0x80, borrow_in=1 → diff=0xFF, borrow_out=1.
- Start ignored while busy: a=100, b=1; after 2 edges pulse start with a=0, b=0 → result is still diff=99, borrow_out=0, with done exactly WIDTH+1 edges after the first start.
- Back-to-back: hold start=1 with a=10, b=20, then a=20, b=10 presented in the DONE cycle → first done gives diff=0xF6, borrow_out=1. Second done follows WIDTH+1 edges later with diff=10, borrow_out=0. diff holds 0xF6 until then.
- Exhaustive: full_subtractor checked over all 8 input combinations. Module with WIDTH=4 checked over all 512 (a, b, borrow_in) combinations against the reference model {borrow_out, diff} = a − b − borrow_in; fail with $finish on the first mismatch.
